instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction fetch stage directly upstream of the asynchronous-read instruction memory. It owns the program counter and drives the memory address. It captures each returned instruction, tagged with its PC, into a 2-entry fetch queue. The queue presents instructions to decode over a valid/ready handshake, and a redirect input (branch/jump) flushes it. Because the queue decouples decode back-pressure from the memory address path, `out_ready` never feeds `imem_addr`.

## Interface
- `ADDR_WIDTH`, 8: PC / memory address width; must match the memory's address width.
- `DATA_WIDTH`, 12: instruction width.
- `RESET_PC`, 0: PC value loaded at reset.

- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous, active-low reset
- `fetch_en`  in  1  1 = fetching permitted this cycle
- `imem_addr`  out  ADDR_WIDTH  address to instruction memory; equals the PC register (combinational from the register only)
- `imem_instr`  in  DATA_WIDTH  instruction returned combinationally for `imem_addr`
- `redirect_valid`  in  1  load a new PC and flush the queue
- `redirect_pc`  in  ADDR_WIDTH  target PC for the redirect
- `out_valid`  out  1  queue head is valid
- `out_ready`  in  1  decode accepts the head this cycle
- `out_instr`  out  DATA_WIDTH  head instruction
- `out_pc`  out  ADDR_WIDTH  PC of the head instruction

## Operation
- State:
  - `pc` register.
  - 2-entry queue, each entry {instr, pc}, with a head pointer and `count` in 0..2.
- Per-cycle events:
  - push = `fetch_en` && !`redirect_valid` && `count` < 2.
  - pop = `out_valid` && `out_ready`.
- On push:
  - The entry {`imem_instr`, `pc`} is written at the tail.
  - `pc` becomes `pc`+1 modulo 2^ADDR_WIDTH; the PC after all-ones wraps to 0.
- On pop: the head advances.
- Count update: `count` += push − pop. Simultaneous push and pop at `count`=1 or 2 is legal and leaves `count` unchanged.
  - Push is gated on `count` < 2, not on pop. A full queue therefore stalls fetch for one cycle even when decode pops.
- Redirect (`redirect_valid`=1) has priority over everything else:
  - `pc` is set to `redirect_pc`.
  - `count` is set to 0 and the head pointer to 0.
  - No push occurs.
  - A pop in the same cycle still counts as a completed handshake for decode; the remaining entries are discarded.
- Outputs:
  - `out_valid` = (`count` != 0).
  - `out_instr`/`out_pc` come from the head entry when valid and are driven to 0 when `out_valid`=0.
- `fetch_en`=0 stalls the PC and blocks pushes. Queued entries still drain.
- `out_valid` and the head contents are stable while `out_valid`=1 and `out_ready`=0 (AXI-style hold). The head changes only on pop or redirect.

## Timing
- Reset (async assert, any time including mid-operation):
  - `pc`=RESET_PC, `count`=0, head pointer 0.
  - `out_valid`=0, `out_instr`=0, `out_pc`=0, `imem_addr`=RESET_PC.
  - Outputs reach these values immediately, without waiting for a clock edge.
- Fetch latency: the instruction at PC p is pushed at the edge ending the cycle where `imem_addr`=p. It appears with `out_valid`=1 in the next cycle, so there is 1 cycle from address to output.
- Throughput:
  - 1 instruction/cycle sustained while `out_ready`=1 and `fetch_en`=1; `count` settles at 1.
  - With `out_ready`=0, `count` reaches 2 after 2 pushes and `pc` stops advancing.
- Redirect latency:
  - In the cycle after `redirect_valid`, `imem_addr`=`redirect_pc` and `out_valid`=0.
  - The target instruction is visible on the output 2 cycles after `redirect_valid`.
- The `imem_addr` path depends only on flops; there is no combinational path from `out_ready`, `redirect_*` or `fetch_en` to `imem_addr`.

## Test plan
- Reset then straight-line run:
  - Stimulus: memory word n = 0x100+n; `fetch_en`=1, `out_ready`=1.
  - Required: `out_valid` rises 1 cycle after reset release. The bench sees (`out_pc`,`out_instr`) = (0,0x100),(1,0x101),(2,0x102)… on consecutive cycles.
- Back-pressure:
  - Stimulus: hold `out_ready`=0 for 5 cycles, then release.
  - Required: `count` saturates at 2 and `pc` freezes at 2. Head stays (0,0x100) throughout the hold. After release the stream continues 0,1,2,3… with no skipped or duplicated PC.
- Redirect mid-stream:
  - Stimulus: with queue full (PCs 4,5), pulse `redirect_valid` with `redirect_pc`=0x40 while `out_ready`=1.
  - Required: PC 4 is accepted that cycle, PC 5 is discarded, and `out_valid`=0 the next cycle. The next delivered entry is (0x40, mem[0x40]).
- Wrap-around:
  - Stimulus: redirect to 0xFE, then free-run.
  - Required: delivered PCs are 0xFE, 0xFF, 0x00, 0x01.
- `fetch_en` gating:
  - Stimulus: drop `fetch_en` for 3 cycles with 1 entry queued and `out_ready`=1.
  - Required: the queued entry drains and `out_valid`=0 for the remainder of the gap. `pc` is unchanged, and fetch resumes at the held PC.
- Async reset mid-run:
  - Stimulus: assert `rst_n`=0 between clock edges with `count`=2.
  - Required: outputs go to 0 and `imem_addr` to RESET_PC before the next edge. After release, the first delivered PC is RESET_PC.

Source files
------------

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, drives the async-read instruction memory,
// and buffers {instr, pc} pairs in a 2-entry queue presented to decode over valid/ready.
module instr_fetch #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 12,
    parameter int RESET_PC   = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fetch_en,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic [DATA_WIDTH-1:0] imem_instr,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_instr,
    output logic [ADDR_WIDTH-1:0] out_pc
);

    localparam logic [ADDR_WIDTH-1:0] RESET_PC_L = ADDR_WIDTH'(RESET_PC);
    localparam logic [ADDR_WIDTH-1:0] PC_ONE     = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    logic [ADDR_WIDTH-1:0] pc_r;
    logic [DATA_WIDTH-1:0] instr_q_r [2];
    logic [ADDR_WIDTH-1:0] pc_q_r    [2];
    logic                  head_r;
    logic [1:0]            count_r;

    logic                  head_valid_s;
    logic                  push_s;
    logic                  pop_s;
    logic                  tail_s;

    // Address comes straight from the PC flop so decode back-pressure never reaches memory.
    assign imem_addr = pc_r;

    // Handshake events; push is gated on occupancy only, never on a same-cycle pop.
    always_comb begin
        head_valid_s = (count_r != 2'd0);
        pop_s        = head_valid_s && out_ready;
        push_s       = fetch_en && !redirect_valid && (count_r < 2'd2);
        tail_s       = head_r ^ count_r[0];
    end

    // PC, queue storage and occupancy; redirect flushes and overrides any push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_r    <= RESET_PC_L;
            head_r  <= 1'b0;
            count_r <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                instr_q_r[i] <= '0;
                pc_q_r[i]    <= '0;
            end
        end else if (redirect_valid) begin
            pc_r    <= redirect_pc;
            head_r  <= 1'b0;
            count_r <= 2'd0;
        end else begin
            if (push_s) begin
                instr_q_r[tail_s] <= imem_instr;
                pc_q_r[tail_s]    <= pc_r;
                pc_r              <= pc_r + PC_ONE;
            end
            if (pop_s) begin
                head_r <= ~head_r;
            end
            count_r <= count_r + {1'b0, push_s} - {1'b0, pop_s};
        end
    end

    // Head presentation; payload is forced to zero whenever the queue is empty.
    always_comb begin
        out_valid = 1'b0;
        out_instr = '0;
        out_pc    = '0;
        if (head_valid_s) begin
            out_valid = 1'b1;
            out_instr = instr_q_r[head_r];
            out_pc    = pc_q_r[head_r];
        end else begin
            out_valid = 1'b0;
            out_instr = '0;
            out_pc    = '0;
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: memory word n = 0x100+n, checks every step with
// immediate assertions against hand-computed values.
module tb_instr_fetch;

    logic        clk;
    logic        rst_n;
    logic        fetch_en;
    logic [7:0]  imem_addr;
    logic [11:0] imem_instr;
    logic        redirect_valid;
    logic [7:0]  redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] out_instr;
    logic [7:0]  out_pc;

    int total;
    int bad;

    instr_fetch #(.ADDR_WIDTH(8), .DATA_WIDTH(12), .RESET_PC(0)) dut (
        .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en), .imem_addr(imem_addr),
        .imem_instr(imem_instr), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc)
    );

    // Async-read memory model.
    assign imem_instr = 12'h100 + {4'h0, imem_addr};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_head(input string tag, input logic v, input logic [7:0] p, input logic [11:0] ins);
        chk({tag, "_valid"}, {31'd0, out_valid}, {31'd0, v});
        chk({tag, "_pc"},    {24'd0, out_pc},    {24'd0, p});
        chk({tag, "_instr"}, {20'd0, out_instr}, {20'd0, ins});
    endtask

    task automatic chk_addr(input string tag, input logic [7:0] a);
        chk({tag, "_addr"}, {24'd0, imem_addr}, {24'd0, a});
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        total          = 0;
        bad            = 0;
        rst_n          = 1'b0;
        fetch_en       = 1'b0;
        out_ready      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 8'h00;

        // Reset state, then straight-line run.
        #2;
        chk_head("rst", 1'b0, 8'h00, 12'h000);
        chk_addr("rst", 8'h00);
        tick;
        fetch_en  = 1'b1;
        out_ready = 1'b1;
        rst_n     = 1'b1;
        chk_head("rel", 1'b0, 8'h00, 12'h000);
        for (int k = 0; k < 4; k++) begin
            tick;
            chk_head("run", 1'b1, 8'(k), 12'h100 + 12'(k));
            chk_addr("run", 8'(k + 1));
        end

        // Back-pressure from reset: queue fills with PCs 0,1 and PC freezes at 2.
        rst_n     = 1'b0;
        out_ready = 1'b0;
        tick;
        rst_n = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tick;
            chk_head("hold", 1'b1, 8'h00, 12'h100);
            chk_addr("hold", (i < 2) ? 8'(i) : 8'h02);
        end
        out_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick;
            chk_head("drain", 1'b1, 8'(k), 12'h100 + 12'(k));
        end

        // Fill queue with PCs 4,5 then redirect while decode accepts PC 4.
        out_ready = 1'b0;
        tick;
        chk_head("full", 1'b1, 8'h04, 12'h104);
        chk_addr("full", 8'h06);
        out_ready      = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 8'h40;
        tick;
        redirect_valid = 1'b0;
        chk_head("redir1", 1'b0, 8'h00, 12'h000);
        chk_addr("redir1", 8'h40);
        tick;
        chk_head("redir2", 1'b1, 8'h40, 12'h140);

        // Wrap-around through 0xFF.
        redirect_valid = 1'b1;
        redirect_pc    = 8'hFE;
        tick;
        redirect_valid = 1'b0;
        chk_head("wrap0", 1'b0, 8'h00, 12'h000);
        chk_addr("wrap0", 8'hFE);
        tick;
        chk_head("wrapFE", 1'b1, 8'hFE, 12'h1FE);
        tick;
        chk_head("wrapFF", 1'b1, 8'hFF, 12'h1FF);
        tick;
        chk_head("wrap00", 1'b1, 8'h00, 12'h100);
        tick;
        chk_head("wrap01", 1'b1, 8'h01, 12'h101);

        // fetch_en gap: PC 1 drains, PC holds at 2, fetch resumes there.
        fetch_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick;
            chk_head("gap", 1'b0, 8'h00, 12'h000);
            chk_addr("gap", 8'h02);
        end
        fetch_en = 1'b1;
        tick;
        chk_head("resume", 1'b1, 8'h02, 12'h102);

        // Async reset between edges with queue full.
        out_ready = 1'b0;
        tick;
        chk_head("pre_rst", 1'b1, 8'h02, 12'h102);
        chk_addr("pre_rst", 8'h04);
        #3;
        rst_n = 1'b0;
        #1;
        chk_head("async_rst", 1'b0, 8'h00, 12'h000);
        chk_addr("async_rst", 8'h00);
        tick;
        out_ready = 1'b1;
        rst_n     = 1'b1;
        tick;
        chk_head("post_rst", 1'b1, 8'h00, 12'h100);
        chk_addr("post_rst", 8'h01);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
